// File: rtl/wrr_pkt_sched.sv
// Weighted round-robin packet scheduler: merges N valid/ready streams onto one, never interleaving packets.
// Optional starvation release of a stalled lock is compiled in with `define WRR_PKT_SCHED_TIMEOUT_EN.
module wrr_pkt_sched #(
  parameter int N       = 4,
  parameter int WIDTH   = 256,
  parameter int WW      = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N-1:0]              in_valid,
  output logic [N-1:0]              in_ready,
  input  logic [N-1:0][WIDTH-1:0]   in_data,
  input  logic [N-1:0]              in_last,
  input  logic [N-1:0][WW-1:0]      weight,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic                      out_last,
  output logic                      busy,
  output logic [$clog2(N)-1:0]      grant_idx,
  output logic                      timeout_pulse
);
  localparam int IW = $clog2(N);
  localparam logic [0:0]  S_IDLE   = 1'b0;
  localparam logic [0:0]  S_LOCKED = 1'b1;
  localparam logic [WW:0] ONE_W    = 1;

  logic [0:0]    state_q, state_d;
  logic [IW-1:0] grant_q, grant_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [WW-1:0] pkt_cnt_q, pkt_cnt_d;
  logic [IW-1:0] pick_idx, cand, next_idx;
  logic [WW:0]   n_pkts, w_eff;
  logic          locked, pkt_end, release_to;

  assign locked    = (state_q == S_LOCKED);
  assign out_valid = locked && in_valid[grant_q];
  assign out_data  = in_data[grant_q];
  assign out_last  = in_last[grant_q];
  assign pkt_end   = out_valid && out_ready && out_last;
  assign busy      = locked;
  assign grant_idx = grant_q;

  always_comb begin
    in_ready = '0;
    if (locked) in_ready[grant_q] = out_ready;
  end

  // Scan ptr, ptr+1, ... mod N; walking backwards lets the nearest requester win.
  always_comb begin
    pick_idx = ptr_q;
    cand     = ptr_q;
    for (int i = N - 1; i >= 0; i--) begin
      cand = IW'((int'(ptr_q) + i) % N);
      if (in_valid[cand]) pick_idx = cand;
    end
  end

  assign next_idx = (grant_q == IW'(N - 1)) ? '0 : grant_q + IW'(1);
  assign n_pkts   = ((grant_q == ptr_q) ? {1'b0, pkt_cnt_q} : '0) + ONE_W;
  assign w_eff    = (weight[grant_q] == '0) ? ONE_W : {1'b0, weight[grant_q]};

  always_comb begin
    // NOTE: every next-state signal gets its hold value first, so no path leaves it unassigned (no latch).
    state_d   = state_q;
    grant_d   = grant_q;
    ptr_d     = ptr_q;
    pkt_cnt_d = pkt_cnt_q;
    if (state_q == S_IDLE) begin
      if (|in_valid) begin
        state_d = S_LOCKED;
        grant_d = pick_idx;
        if (pick_idx != ptr_q) pkt_cnt_d = '0;
      end
    end else if (pkt_end) begin
      state_d = S_IDLE;
      if (n_pkts >= w_eff) begin
        ptr_d     = next_idx;
        pkt_cnt_d = '0;
      end else begin
        ptr_d     = grant_q;
        pkt_cnt_d = n_pkts[WW-1:0];
      end
    end else if (release_to) begin
      state_d   = S_IDLE;
      ptr_d     = next_idx;
      pkt_cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values, independent of block order.
    if (rst) begin
      state_q   <= S_IDLE;
      grant_q   <= '0;
      ptr_q     <= '0;
      pkt_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      ptr_q     <= ptr_d;
      pkt_cnt_q <= pkt_cnt_d;
    end
  end

`ifdef WRR_PKT_SCHED_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] starve_q, starve_d;
  logic          timeout_pulse_q;

  // Release fires on the cycle the starvation count would reach TIMEOUT; the pulse shows in IDLE.
  assign release_to    = locked && !in_valid[grant_q] && (starve_q == TW'(TIMEOUT - 1));
  assign timeout_pulse = timeout_pulse_q;

  always_comb begin
    starve_d = '0;
    if (locked && !in_valid[grant_q] && !release_to) starve_d = starve_q + TW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_q        <= '0;
      timeout_pulse_q <= 1'b0;
    end else begin
      starve_q        <= starve_d;
      timeout_pulse_q <= release_to;
    end
  end
`else
  assign release_to    = 1'b0;
  assign timeout_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_wrr_pkt_sched.sv
// Self-checking bench for wrr_pkt_sched: vector table, directed corner sequences, and a
// randomized run against a packet-level reference model of the scheduling rules.
module tb_wrr_pkt_sched;
  localparam int N  = 4;
  localparam int W  = 16;
  localparam int WW = 4;
  localparam int TO = 8;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [N-1:0]         in_valid, in_ready, in_last;
  logic [N-1:0][W-1:0]  in_data;
  logic [N-1:0][WW-1:0] weight;
  logic                 out_valid, out_ready, out_last, busy, timeout_pulse;
  logic [W-1:0]         out_data;
  logic [1:0]           grant_idx;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always #5 clk = ~clk;

  wrr_pkt_sched #(.N(N), .WIDTH(W), .WW(WW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .weight(weight),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .busy(busy), .grant_idx(grant_idx), .timeout_pulse(timeout_pulse)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s @cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // {valid, last, data, in_ready, busy, grant, pulse}; last/data masked while not valid.
  function automatic logic [25:0] pack(logic ov, logic ol, logic [W-1:0] d, logic [N-1:0] ir,
                                       logic b, logic [1:0] g, logic p);
    return {ov, ov & ol, ov ? d : {W{1'b0}}, ir, b, g, p};
  endfunction

  function automatic logic [25:0] act_vec();
    return pack(out_valid, out_last, out_data, in_ready, busy, grant_idx, timeout_pulse);
  endfunction

  // ---------------- reference model: packet-level scheduling rules ----------------
  bit m_locked, m_pulse, n_locked, n_pulse;
  int m_g, m_ptr, m_cnt, m_starve, n_g, n_ptr, n_cnt, n_starve;
  logic [25:0]  exp_vec;
  logic [N-1:0] e_ir;

  task automatic model_reset();
    m_locked = 0; m_pulse = 0; m_g = 0; m_ptr = 0; m_cnt = 0; m_starve = 0;
  endtask

  task automatic model_eval();
    logic ov, ol;
    int n, w;
    ov   = m_locked && in_valid[m_g];
    ol   = in_last[m_g];
    e_ir = '0;
    if (m_locked && out_ready) e_ir[m_g] = 1'b1;
    exp_vec = pack(ov, ol, in_data[m_g], e_ir, m_locked, 2'(m_g), m_pulse);
    n_locked = m_locked; n_g = m_g; n_ptr = m_ptr; n_cnt = m_cnt; n_starve = m_starve; n_pulse = 0;
    if (!m_locked) begin
      if (in_valid != '0) begin
        for (int k = 0; k < N; k++) begin
          if (in_valid[(m_ptr + k) % N]) begin
            n_g = (m_ptr + k) % N;
            break;
          end
        end
        n_locked = 1; n_starve = 0;
        if (n_g != m_ptr) n_cnt = 0;
      end
    end else if (ov && out_ready && ol) begin
      n = ((m_g == m_ptr) ? m_cnt : 0) + 1;
      w = (weight[m_g] == '0) ? 1 : int'(weight[m_g]);
      if (n >= w) begin n_ptr = (m_g + 1) % N; n_cnt = 0; end
      else begin n_ptr = m_g; n_cnt = n; end
      n_locked = 0;
    end else begin
`ifdef WRR_PKT_SCHED_TIMEOUT_EN
      if (in_valid[m_g]) n_starve = 0;
      else begin
        n_starve = m_starve + 1;
        if (n_starve >= TO) begin
          n_locked = 0; n_pulse = 1; n_ptr = (m_g + 1) % N; n_cnt = 0; n_starve = 0;
        end
      end
`endif
    end
  endtask

  task automatic model_commit();
    m_locked = n_locked; m_g = n_g; m_ptr = n_ptr; m_cnt = n_cnt; m_starve = n_starve; m_pulse = n_pulse;
  endtask

  // ---------------- compliant packet sources ----------------
  logic [N-1:0] src_en, s_valid;
  int src_len_fixed[N];
  int src_prob = 100;
  int ordy_mode = 0;
  int s_beat[N], s_len[N], s_pkt[N];

  typedef struct { int c; int s; bit l; } acc_t;
  acc_t acc_q[$];
  int first_ov[N];
  int pulse_n, pulse_cyc, lock0_n;
  bit busy_at_pulse;

  function automatic int new_len(int i);
    return (src_len_fixed[i] != 0) ? src_len_fixed[i] : int'($urandom_range(1, 4));
  endfunction

  function automatic bit coin();
    return ($urandom_range(99) < src_prob);
  endfunction

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      in_valid[i] = s_valid[i];
      in_data[i]  = {4'(i), 6'(s_pkt[i]), 6'(s_beat[i])};
      in_last[i]  = (s_beat[i] == s_len[i] - 1);
    end
    case (ordy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
      default: out_ready = ($urandom_range(99) < 75);
    endcase
  endtask

  task automatic src_advance();
    for (int i = 0; i < N; i++) begin
      if (s_valid[i] && e_ir[i]) begin
        s_beat[i]++;
        if (s_beat[i] == s_len[i]) begin
          s_beat[i] = 0; s_pkt[i]++; s_len[i] = new_len(i);
        end
        s_valid[i] = src_en[i] && coin();
      end else if (!s_valid[i]) begin
        s_valid[i] = src_en[i] && coin();
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = '0; in_last = '0; in_data = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < N; i++) begin
      s_beat[i] = 0; s_pkt[i] = 0; s_len[i] = new_len(i);
      s_valid[i] = src_en[i] && coin();
      first_ov[i] = -1;
    end
    acc_q.delete();
    pulse_n = 0; pulse_cyc = -1; lock0_n = 0; busy_at_pulse = 1'b0;
    drive();
  endtask

  // One clock: compare mid-cycle, then advance model and sources past the edge.
  task automatic cycle(input string name);
    #4;
    model_eval();
    check(name, act_vec(), exp_vec);
    if (out_valid && out_ready) acc_q.push_back('{cyc, int'(grant_idx), out_last});
    if (out_valid && first_ov[grant_idx] < 0) first_ov[grant_idx] = cyc;
    if (timeout_pulse) begin
      pulse_n++;
      if (pulse_cyc < 0) begin pulse_cyc = cyc; busy_at_pulse = busy; end
    end
    if (busy && grant_idx == 2'd0) lock0_n++;
    @(posedge clk);
    model_commit();
    src_advance();
    cyc++;
    #1;
    drive();
  endtask

  task automatic check_order(input string name, input int exp[$]);
    int lasts[$];
    int gap_bad;
    gap_bad = 0;
    foreach (acc_q[k]) begin
      if (acc_q[k].l) lasts.push_back(acc_q[k].s);
      if (k > 0 && acc_q[k].c - acc_q[k-1].c != (acc_q[k-1].l ? 2 : 1)) gap_bad++;
    end
    foreach (exp[k]) check(name, (k < lasts.size()) ? lasts[k] : 99, exp[k]);
    check({name, "_gaps"}, gap_bad, 0);
  endtask

  typedef struct {
    logic [3:0] iv, il;
    logic       ordy;
    logic       ov, ol;
    logic [3:0] ir;
    logic       bsy;
    logic [1:0] g;
  } vec_t;

  vec_t vt[16];

  initial begin
    int t_end, n2, n1_early, c0;
    int exp_order[$];

    vt[0]  = '{4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd0};
    vt[1]  = '{4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd0};
    vt[2]  = '{4'b0001, 4'b0001, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd0};
    vt[3]  = '{4'b0001, 4'b0001, 1'b1, 1'b1, 1'b1, 4'b0001, 1'b1, 2'd0};
    vt[4]  = '{4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd0};
    vt[5]  = '{4'b1000, 4'b1000, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd0};
    vt[6]  = '{4'b1000, 4'b1000, 1'b0, 1'b1, 1'b1, 4'b0000, 1'b1, 2'd3};
    vt[7]  = '{4'b1000, 4'b1000, 1'b1, 1'b1, 1'b1, 4'b1000, 1'b1, 2'd3};
    vt[8]  = '{4'b0110, 4'b0000, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd3};
    vt[9]  = '{4'b0110, 4'b0000, 1'b1, 1'b1, 1'b0, 4'b0010, 1'b1, 2'd1};
    vt[10] = '{4'b0110, 4'b0010, 1'b1, 1'b1, 1'b1, 4'b0010, 1'b1, 2'd1};
    vt[11] = '{4'b0110, 4'b0000, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd1};
    vt[12] = '{4'b0110, 4'b0100, 1'b1, 1'b1, 1'b1, 4'b0100, 1'b1, 2'd2};
    vt[13] = '{4'b0010, 4'b0010, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd2};
    vt[14] = '{4'b0010, 4'b0010, 1'b1, 1'b1, 1'b1, 4'b0010, 1'b1, 2'd1};
    vt[15] = '{4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd1};

    rst = 1'b1;
    weight = {4'd1, 4'd1, 4'd1, 4'd1};
    src_en = '0;
    for (int i = 0; i < N; i++) src_len_fixed[i] = 0;

    // reset then idle
    do_reset();
    repeat (10) cycle("idle");

    // vector table from reset: grants, skip of idle requesters, stall, pointer wrap
    do_reset();
    foreach (vt[v]) begin
      in_valid = vt[v].iv; in_last = vt[v].il; out_ready = vt[v].ordy;
      for (int i = 0; i < N; i++) in_data[i] = 16'hA000 + 16'(i);
      #4;
      check($sformatf("vec%0d", v), act_vec(),
            pack(vt[v].ov, vt[v].ol, 16'hA000 + 16'(vt[v].g), vt[v].ir, vt[v].bsy, vt[v].g, 1'b0));
      @(posedge clk);
      cyc++;
      #1;
    end

    // plain round-robin, 2-beat packets, all sources busy
    src_en = 4'b1111; src_prob = 100; ordy_mode = 0;
    for (int i = 0; i < N; i++) src_len_fixed[i] = 2;
    do_reset();
    repeat (26) cycle("rr");
    exp_order = '{0, 1, 2, 3, 0, 1, 2, 3};
    check_order("rr_order", exp_order);

    // weighting {3,1,0,1}
    weight = {4'd1, 4'd0, 4'd1, 4'd3};
    do_reset();
    repeat (32) cycle("wrr");
    exp_order = '{0, 0, 0, 1, 2, 3, 0, 0, 0, 1};
    check_order("wrr_order", exp_order);

    // backpressure: source 2 4-beat packet under stalls, source 1 waiting
    weight = {4'd1, 4'd1, 4'd1, 4'd1};
    src_en = 4'b0100; ordy_mode = 1;
    src_len_fixed[2] = 4; src_len_fixed[1] = 0;
    do_reset();
    cycle("bp");
    src_en = 4'b0110; s_valid[1] = 1'b1; drive();
    repeat (24) cycle("bp");
    t_end = -1; n2 = 0; n1_early = 0;
    foreach (acc_q[k]) if (t_end < 0 && acc_q[k].s == 2 && acc_q[k].l) t_end = acc_q[k].c;
    foreach (acc_q[k]) begin
      if (acc_q[k].s == 2 && acc_q[k].c <= t_end) n2++;
      if (acc_q[k].s == 1 && acc_q[k].c < t_end) n1_early++;
    end
    check("bp_src2_beats", n2, 4);
    check("bp_no_interleave", n1_early, 0);
    check("bp_src1_grant_delay", first_ov[1] - t_end, 2);

    // starvation: source 0 sends one non-last beat then goes quiet, source 1 waits
    src_en = 4'b0011; ordy_mode = 0;
    src_len_fixed[0] = 2; src_len_fixed[1] = 1;
    do_reset();
    c0 = cyc;
    cycle("to");
    src_en = 4'b0010;
    cycle("to");
    lock0_n = 0;
`ifdef WRR_PKT_SCHED_TIMEOUT_EN
    repeat (14) cycle("to");
    check("to_pulse_delay", pulse_cyc - (c0 + 2), TO);
    check("to_pulse_count", pulse_n, 1);
    check("to_idle_at_pulse", busy_at_pulse, 0);
    check("to_next_grant", first_ov[1], pulse_cyc + 1);
`else
    repeat (100) cycle("lock");
    check("lock_held_cycles", lock0_n, 100);
    check("lock_no_pulse", pulse_n, 0);
    check("lock_src1_waits", first_ov[1], -1);
`endif

    // randomized traffic against the model, with a mid-packet reset
    src_en = 4'b1111; src_prob = 70; ordy_mode = 2;
    for (int i = 0; i < N; i++) src_len_fixed[i] = 0;
    do_reset();
    for (int r = 0; r < 1600; r++) begin
      if (r % 250 == 0)
        for (int i = 0; i < N; i++) weight[i] = 4'($urandom_range(0, 3));
      if (r == 800) do_reset();
      cycle("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
